// File: rtl/core_dg_tx.sv
// Hamming(7,4) datagram encoder with a 2-entry output FIFO; optional error injection via CORE_DG_ERR_INJ_EN.
// Latency: one cycle from input transfer to out_valid, sustaining one packet per cycle.
// Backpressure: in_ready drops only when both entries are full and depends on registered state only.
module core_dg_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  pkt_count
`ifdef CORE_DG_ERR_INJ_EN
  ,
  input  logic [2:0]  err_pos
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_nxt;
  logic        live_q;
  logic [10:0] head_q;
  logic [10:0] tail_q;
  logic [6:0]  cw;
  logic [10:0] pkt;
  logic        push;
  logic        pop;

  assign in_ready  = live_q && (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    cw    = '0;
    cw[2] = in_data[4];
    cw[4] = in_data[5];
    cw[5] = in_data[6];
    cw[6] = in_data[7];
    cw[0] = in_data[4] ^ in_data[5] ^ in_data[7];
    cw[1] = in_data[4] ^ in_data[6] ^ in_data[7];
    cw[3] = in_data[5] ^ in_data[6] ^ in_data[7];
`ifdef CORE_DG_ERR_INJ_EN
    // err_pos is 1-based so that zero means "no corruption".
    if (err_pos != 3'd0) begin
      cw = cw ^ (7'd1 << (err_pos - 3'd1));
    end
`endif
    pkt = {cw, in_data[3:0]};
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_EMPTY: if (push) state_nxt = S_ONE;
      S_ONE: begin
        if (push && !pop)      state_nxt = S_TWO;
        else if (!push && pop) state_nxt = S_EMPTY;
      end
      S_TWO:   if (pop) state_nxt = S_ONE;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      live_q  <= 1'b1;
    end
  end

  // head_q is always the oldest packet, so out_data never passes through a mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state_q)
        S_EMPTY: if (push) head_q <= pkt;
        S_ONE: begin
          if (push && pop) head_q <= pkt;
          else if (push)   tail_q <= pkt;
        end
        S_TWO:   if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (pop) begin
      pkt_count <= pkt_count + 8'd1;
    end
  end

endmodule

// File: doc/core_dg_tx.md
CORE_DG_TX -- requirements
Module: core_dg_tx

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_data  input  8  source word: [7:4] 4-bit payload D3..D0, [3:0] 4-bit destination IP.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 out_data  output  11  router packet: [10:4] 7-bit Hamming codeword, [3:0] destination IP.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_ready  input  1  router accepts out_data this cycle.
REQ-010 pkt_count  output  8  count of packets delivered, modulo 256.

Function
REQ-011 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-012 The codeword bits SHALL be: cw[2]=D0, cw[4]=D1, cw[5]=D2, cw[6]=D3, cw[0]=D0^D1^D3, cw[1]=D0^D2^D3, cw[3]=D1^D2^D3.
REQ-013 out_data[3:0] SHALL equal in_data[3:0] unchanged.
REQ-014 Encoding SHALL occur at input transfer; the encoded 11-bit packet is stored in a 2-entry FIFO.
REQ-015 The FIFO SHALL be controlled by a 3-state occupancy FSM: EMPTY, ONE, TWO.
- EMPTY: push -> ONE.
- ONE: push only -> TWO; pop only -> EMPTY; push+pop -> ONE.
- TWO: pop -> ONE; push not possible.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; it is a function of registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 in ONE and TWO; out_data SHALL be the oldest entry, driven from registers.
REQ-018 Latency SHALL be one cycle: a packet accepted at edge N is visible on out_data with out_valid=1 after edge N.
REQ-019 Sustained throughput SHALL be one packet per cycle when out_ready stays 1.
REQ-020 Packets SHALL leave in acceptance order, with no loss or duplication.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-022 In state ONE with simultaneous push and pop, the new packet SHALL appear on out_data on the next cycle.
REQ-023 pkt_count SHALL increment by 1 on each output transfer and wrap from 255 to 0.

Reset
REQ-024 While rst_n=0, the FSM SHALL be EMPTY, out_valid=0, in_ready=0, out_data=0 and pkt_count=0.
REQ-025 After rst_n is released, in_ready SHALL rise on the first clk edge.
REQ-026 Reset asserted mid-operation SHALL discard all stored packets immediately; no partial packet is emitted afterwards.

Configuration
REQ-027 When the macro CORE_DG_ERR_INJ_EN is defined, the block SHALL add input err_pos[2:0].
- err_pos is sampled at each input transfer.
- A nonzero value SHALL invert codeword bit cw[err_pos-1] of that packet before it is stored.
- err_pos=0 SHALL leave the packet unchanged.
- This provides single-bit errors for exercising downstream correction.
REQ-028 When CORE_DG_ERR_INJ_EN is undefined, the err_pos port SHALL be absent and codewords are always unmodified.

Verification
REQ-029 Reset: hold rst_n=0 -> out_valid=0, in_ready=0, pkt_count=0; release -> in_ready=1 after one edge.
REQ-030 Encoding, out_ready=1:
- in_data=8'hB3 -> out_data=11'h553.
- in_data=8'h0C -> out_data=11'h00C.
- in_data=8'hFA -> out_data=11'h7FA.
- Each appears one cycle after acceptance.
REQ-031 Backpressure: out_ready=0, push 8'hB3 then 8'hFA -> FSM reaches TWO, in_ready=0, out_data holds 11'h553; raise out_ready -> 11'h553 then 11'h7FA, in order.
REQ-032 Streaming: 300 back-to-back pushes with out_ready=1 -> one packet per cycle, pkt_count=44 (300 mod 256) after the last transfer.
REQ-033 Reset mid-stream: assert rst_n=0 while in state TWO -> out_valid=0 immediately; after release, no stale packet appears.
REQ-034 With CORE_DG_ERR_INJ_EN defined: in_data=8'hB3, err_pos=3 -> out_data=11'h513 (cw[2] inverted); err_pos=0 -> 11'h553.
